// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control: opcodes, functs, ALU codes,
// FSM states and the instruction classes produced by the decoder.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] MIPS_RTYPE = 6'h00;
  localparam logic [5:0] MIPS_J     = 6'h02;
  localparam logic [5:0] MIPS_BEQ   = 6'h04;
  localparam logic [5:0] MIPS_BNE   = 6'h05;
  localparam logic [5:0] MIPS_ADDI  = 6'h08;
  localparam logic [5:0] MIPS_ANDI  = 6'h0c;
  localparam logic [5:0] MIPS_ORI   = 6'h0d;
  localparam logic [5:0] MIPS_LW    = 6'h23;
  localparam logic [5:0] MIPS_SW    = 6'h2b;

  localparam logic [5:0] MIPS_ADD   = 6'h20;
  localparam logic [5:0] MIPS_SUB   = 6'h22;
  localparam logic [5:0] MIPS_AND   = 6'h24;
  localparam logic [5:0] MIPS_OR    = 6'h25;
  localparam logic [5:0] MIPS_SLT   = 6'h2a;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_SLT    = 3'b100;
  localparam logic [2:0] ALU_UNDEF  = 3'b111;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WR = 4'd6,
    ST_WB_R   = 4'd7,
    ST_WB_I   = 4'd8,
    ST_WB_LD  = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_TRAP   = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    IC_R    = 3'd0,
    IC_I    = 3'd1,
    IC_LW   = 3'd2,
    IC_SW   = 3'd3,
    IC_BEQ  = 3'd4,
    IC_BNE  = 3'd5,
    IC_JUMP = 3'd6,
    IC_INV  = 3'd7
  } iclass_e;

  // States that hold a memory access open and therefore run the wait counter.
  function automatic logic is_mem_wait(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_instr_class.sv
// Combinational instruction classifier: opcode/funct to class, ALU operation
// and an invalid flag for encodings the core does not implement.
module mips_instr_class
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] i_opc,
  input  logic [5:0] i_func,
  output iclass_e    o_iclass,
  output logic [2:0] o_aluFunc,
  output logic       o_invalid
);

  always_comb begin
    o_iclass  = IC_INV;
    o_aluFunc = ALU_UNDEF;
    case (i_opc)
      MIPS_RTYPE: begin
        case (i_func)
          MIPS_ADD: begin o_iclass = IC_R; o_aluFunc = ALU_ADD; end
          MIPS_SUB: begin o_iclass = IC_R; o_aluFunc = ALU_SUB; end
          MIPS_AND: begin o_iclass = IC_R; o_aluFunc = ALU_AND; end
          MIPS_OR:  begin o_iclass = IC_R; o_aluFunc = ALU_OR;  end
          MIPS_SLT: begin o_iclass = IC_R; o_aluFunc = ALU_SLT; end
          default:  ;
        endcase
      end
      MIPS_LW:   begin o_iclass = IC_LW;   o_aluFunc = ALU_ADD; end
      MIPS_SW:   begin o_iclass = IC_SW;   o_aluFunc = ALU_ADD; end
      MIPS_BEQ:  begin o_iclass = IC_BEQ;  o_aluFunc = ALU_SUB; end
      MIPS_BNE:  begin o_iclass = IC_BNE;  o_aluFunc = ALU_SUB; end
      MIPS_J:    begin o_iclass = IC_JUMP; end
      MIPS_ADDI: begin o_iclass = IC_I;    o_aluFunc = ALU_ADD; end
      MIPS_ANDI: begin o_iclass = IC_I;    o_aluFunc = ALU_AND; end
      MIPS_ORI:  begin o_iclass = IC_I;    o_aluFunc = ALU_OR;  end
      default:   ;
    endcase
  end

  assign o_invalid = (o_iclass == IC_INV);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and traps on unsupported encodings or memory accesses that never complete.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       aluZero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       irWrite,
  output logic       iOrD,
  output logic       memRead,
  output logic       memWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluFunc,
  output logic       bitXtend,
  output logic       rfWriteEnable,
  output logic       rfWriteAddrSel,
  output logic [1:0] rfWriteDataSel,
  output logic       invOpcode,
  output logic       busErr,
  output logic [3:0] state
);

  state_e           r_state;
  state_e           w_next;
  iclass_e          r_iclass;
  iclass_e          w_iclass;
  logic [2:0]       r_aluFunc;
  logic [2:0]       w_aluFunc;
  logic             w_invalid;
  logic [CNT_W-1:0] r_cnt;
  logic             r_invOpcode;
  logic             r_busErr;
  logic             w_memWait;
  logic             w_timeout;

  mips_instr_class u_instr_class (
    .i_opc     (opc),
    .i_func    (func),
    .o_iclass  (w_iclass),
    .o_aluFunc (w_aluFunc),
    .o_invalid (w_invalid)
  );

  // The counter holds the number of wait cycles already spent; once it equals
  // MEM_TIMEOUT a further cycle without memReady traps, while memReady wins.
  assign w_memWait = is_mem_wait(r_state);
  assign w_timeout = w_memWait && !memReady && (r_cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FETCH;
      r_cnt       <= '0;
      r_invOpcode <= 1'b0;
      r_busErr    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_memWait && !memReady && !w_timeout)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
      if (r_state == ST_DECODE && w_invalid)
        r_invOpcode <= 1'b1;
      if (w_timeout)
        r_busErr <= 1'b1;
    end
  end

  // Decoded instruction fields, captured once per instruction in DECODE.
  always_ff @(posedge clk) begin
    if (r_state == ST_DECODE) begin
      r_iclass  <= w_iclass;
      r_aluFunc <= w_aluFunc;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (memReady)       w_next = ST_DECODE;
        else if (w_timeout) w_next = ST_TRAP;
      end
      ST_DECODE: begin
        case (w_iclass)
          IC_R:           w_next = ST_EXEC_R;
          IC_I:           w_next = ST_EXEC_I;
          IC_LW, IC_SW:   w_next = ST_ADDR;
          IC_BEQ, IC_BNE: w_next = ST_BRANCH;
          IC_JUMP:        w_next = ST_JUMP;
          default:        w_next = ST_TRAP;
        endcase
      end
      ST_EXEC_R: w_next = ST_WB_R;
      ST_EXEC_I: w_next = ST_WB_I;
      ST_ADDR:   w_next = (r_iclass == IC_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (memReady)       w_next = ST_WB_LD;
        else if (w_timeout) w_next = ST_TRAP;
      end
      ST_MEM_WR: begin
        if (memReady)       w_next = ST_FETCH;
        else if (w_timeout) w_next = ST_TRAP;
      end
      ST_WB_R, ST_WB_I, ST_WB_LD, ST_BRANCH, ST_JUMP: w_next = ST_FETCH;
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_TRAP;
    endcase
  end

  always_comb begin
    pcWrite        = 1'b0;
    pcSrc          = PCSRC_ALU;
    irWrite        = 1'b0;
    iOrD           = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    aluSrcA        = 1'b0;
    aluSrcB        = SRCB_RT;
    aluFunc        = ALU_ADD;
    bitXtend       = 1'b0;
    rfWriteEnable  = 1'b0;
    rfWriteAddrSel = 1'b0;
    rfWriteDataSel = 2'b00;
    case (r_state)
      ST_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
      end
      ST_DECODE: begin
        aluSrcB  = SRCB_IMMSH;
        bitXtend = 1'b1;
      end
      ST_EXEC_R: begin
        aluSrcA = 1'b1;
        aluFunc = r_aluFunc;
      end
      ST_EXEC_I: begin
        aluSrcA  = 1'b1;
        aluSrcB  = SRCB_IMM;
        aluFunc  = r_aluFunc;
        bitXtend = (r_aluFunc == ALU_ADD);
      end
      ST_ADDR: begin
        aluSrcA  = 1'b1;
        aluSrcB  = SRCB_IMM;
        bitXtend = 1'b1;
      end
      ST_MEM_RD: begin
        memRead = 1'b1;
        iOrD    = 1'b1;
      end
      ST_MEM_WR: begin
        memWrite = 1'b1;
        iOrD     = 1'b1;
      end
      ST_WB_R: begin
        rfWriteEnable  = 1'b1;
        rfWriteAddrSel = 1'b1;
      end
      ST_WB_I: rfWriteEnable = 1'b1;
      ST_WB_LD: begin
        rfWriteEnable  = 1'b1;
        rfWriteDataSel = 2'b01;
      end
      ST_BRANCH: begin
        aluSrcA = 1'b1;
        aluFunc = ALU_SUB;
        pcSrc   = PCSRC_BR;
        pcWrite = (r_iclass == IC_BNE) ? !aluZero : aluZero;
      end
      ST_JUMP: begin
        pcWrite = 1'b1;
        pcSrc   = PCSRC_JMP;
      end
      default: ;
    endcase
    // Reset aborts whatever state is held: no datapath write may happen.
    if (reset) begin
      pcWrite       = 1'b0;
      irWrite       = 1'b0;
      memRead       = 1'b0;
      memWrite      = 1'b0;
      rfWriteEnable = 1'b0;
    end
  end

  assign state     = r_state;
  assign invOpcode = r_invOpcode;
  assign busErr    = r_busErr;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle control FSM that sequences the MIPS datapath (PC, IR, register file, ALU, unified memory) one instruction at a time. It takes opcode/funct from the IR plus the ALU zero flag and a memory-ready handshake. It drives every datapath select/enable per state and traps on unsupported encodings or memory timeout. It replaces the single-cycle decoder as the top-level control in the multicycle core.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory access may wait for memReady before bus-error trap (≥1)
CNT_W, 5, width of wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
opc  in  6  IR[31:26]; sampled in DECODE only
func  in  6  IR[5:0]; sampled in DECODE only
aluZero  in  1  ALU zero flag, valid in BRANCH
memReady  in  1  memory completes current access this cycle
pcWrite  out  1  load PC
pcSrc  out  2  00 ALU result (PC+4), 01 branch target register, 10 jump target
irWrite  out  1  load IR from memory read data
iOrD  out  1  memory address: 0 PC, 1 ALUOut
memRead  out  1  memory read request
memWrite  out  1  memory write request
aluSrcA  out  1  0 PC, 1 rs
aluSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
aluFunc  out  3  ALU operation code
bitXtend  out  1  1 sign-extend imm, 0 zero-extend
rfWriteEnable  out  1  register-file write
rfWriteAddrSel  out  1  0 rt, 1 rd
rfWriteDataSel  out  2  00 ALUOut, 01 memory data register
invOpcode  out  1  sticky: unsupported opc/func trapped
busErr  out  1  sticky: memory timeout trapped
state  out  4  current state encoding, for debug/bench

Behaviour:
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_LD, BRANCH, JUMP, TRAP. Outputs are Moore: functions of state plus class/func registered in DECODE.
- Reset: state=FETCH, wait counter=0, invOpcode=0, busErr=0. While reset is high, all enables (pcWrite, irWrite, memRead, memWrite, rfWriteEnable) are 0. Reset mid-instruction aborts it; no writes occur in the reset cycle.
- Unasserted selects in any state are 0, not X.
- FETCH: memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluFunc=ADD. Stay while memReady=0. On memReady=1, same cycle: irWrite=1, pcWrite=1, pcSrc=00, then go to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, bitXtend=1, aluFunc=ADD (branch target). Register instruction class:
  - opc 0x00 with func 0x20/0x22/0x24/0x25/0x2a → EXEC_R
  - 0x23 LW, 0x2b SW → ADDR
  - 0x04 BEQ, 0x05 BNE → BRANCH
  - 0x02 J → JUMP
  - 0x08 ADDI, 0x0c ANDI, 0x0d ORI → EXEC_I
  - anything else → TRAP with invOpcode=1
- EXEC_R: aluSrcA=1, aluSrcB=00, aluFunc from func (ADD/SUB/AND/OR/SLT) → WB_R.
- WB_R: rfWriteEnable=1, rfWriteAddrSel=1, rfWriteDataSel=00 → FETCH.
- EXEC_I: aluSrcA=1, aluSrcB=10. ADDI: bitXtend=1, ADD. ANDI/ORI: bitXtend=0, AND/OR. → WB_I.
- WB_I: rfWriteEnable=1, rfWriteAddrSel=0, rfWriteDataSel=00 → FETCH.
- ADDR: aluSrcA=1, aluSrcB=10, bitXtend=1, ADD → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: memRead=1, iOrD=1; on memReady → WB_LD.
- MEM_WR: memWrite=1, iOrD=1; on memReady → FETCH.
- WB_LD: rfWriteEnable=1, rfWriteAddrSel=0, rfWriteDataSel=01 → FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluFunc=SUB, pcSrc=01. pcWrite=aluZero for BEQ, !aluZero for BNE → FETCH.
- JUMP: pcWrite=1, pcSrc=10 → FETCH.
- Memory wait counter:
  - Cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle memReady=0 in those states.
  - When it reaches MEM_TIMEOUT with memReady still 0 → TRAP, busErr=1.
  - memReady=1 in the same cycle the count hits MEM_TIMEOUT wins: access completes, no trap.
- TRAP: all enables 0; absorbing until reset.
- Latency with zero-wait memory (memReady tied 1): R/I-type 4 cycles, LW 5, SW 4, branch 3, jump 3. Each memory wait cycle adds 1.

Decomposition:
- Shared header mips_defs.vh holds:
  - MIPS_* opcode/funct defines: MIPS_AND=0x24, MIPS_LW=0x23, MIPS_BNE=0x05, etc.
  - ALU_* codes: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=100, ALU_UNDEF=111.
  - State encodings.
- One combinational sub-module, mips_instr_class: opc/func → class + aluFunc + invalid. Used by DECODE; unit-testable alone.

Test Plan:
- memReady=1; reset 2 cycles then release; IR = AND (opc 0, func 0x24) → states FETCH,DECODE,EXEC_R,WB_R. In WB_R: rfWriteEnable=1, rfWriteAddrSel=1, rfWriteDataSel=00. aluFunc=010 in EXEC_R.
- LW (0x23) with memReady low 3 cycles in MEM_RD → MEM_RD held 4 cycles with memRead=1, iOrD=1. Then WB_LD with rfWriteDataSel=01; total 8 cycles.
- BNE (0x05): aluZero=1 → pcWrite=0 in BRANCH. Repeat with aluZero=0 → pcWrite=1, pcSrc=01.
- opc 0x2a, then separately opc 0/func 0x2f → TRAP after DECODE, invOpcode=1. No enable asserts afterwards for 20 cycles; reset clears invOpcode.
- MEM_TIMEOUT=4; memReady held 0 in FETCH → TRAP, busErr=1 after the 4th wait cycle. Second run raising memReady exactly on the 4th cycle → DECODE, busErr=0.
- Assert reset during MEM_WR → next cycle state=FETCH, memWrite=0, sticky flags 0.
